// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, frame constants and bit-timing helpers
package uart_pkg;

  // Receiver/transmitter FSM encodings, kept as plain constants for legacy tools
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  // 8N1 framing: start + 8 data + stop
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // Clock cycles per serial bit
  function automatic int calc_period(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

  // Mid-bit sample point within one bit period
  function automatic int calc_half(input int period);
    return (period - 1) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial input and received-byte outputs of the UART receiver
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  // Receiver side: samples the line, drives the byte and status strobes
  modport master (
    input  rx_in,
    output data,
    output rx_done,
    output frame_err,
    output busy
  );

  // Line/consumer side: drives the line, observes the byte and status strobes
  modport slave (
    output rx_in,
    input  data,
    input  rx_done,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the serial line plus falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_i,
  output logic synced_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resolve metastability on the pin and keep one cycle of history; all flops idle high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign synced_o = sync_q;
  assign fall_o   = ~sync_q & prev_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with single-cycle byte and framing-error strobes
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.master rx_if
);

  localparam int PERIOD = calc_period(CLK_FREQ, UART_BPS);
  localparam int HALF   = calc_half(PERIOD);

  localparam logic [15:0] CNT_LAST = 16'(PERIOD - 1);
  localparam logic [15:0] CNT_HALF = 16'(HALF);
  localparam logic [2:0]  BIT_LAST = 3'(DATA_BITS - 1);

  logic        synced;
  logic        fall;

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt0_q, cnt0_d;
  logic [2:0]  cnt1_q, cnt1_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_i     (rx_if.rx_in),
    .synced_o (synced),
    .fall_o   (fall)
  );

  // Frame sequencing: bit timer, bit index, mid-bit sampling and result strobes
  always_comb begin
    state_d = state_q;
    cnt0_d  = cnt0_q;
    cnt1_d  = cnt1_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (state_q != IDLE) begin
      cnt0_d = (cnt0_q == CNT_LAST) ? 16'd0 : cnt0_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt0_d  = 16'd0;
        end
      end
      START: begin
        // A line already back high at mid-start was a glitch, not a frame
        if (cnt0_q == CNT_HALF && synced) begin
          state_d = IDLE;
          cnt0_d  = 16'd0;
        end else if (cnt0_q == CNT_LAST) begin
          state_d = DATA;
          cnt1_d  = 3'd0;
        end
      end
      DATA: begin
        if (cnt0_q == CNT_HALF) begin
          shift_d[cnt1_q] = synced;
        end
        if (cnt0_q == CNT_LAST) begin
          cnt1_d = cnt1_q + 3'd1;
          if (cnt1_q == BIT_LAST) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // Leave at mid-stop so a following start bit is caught after a 1-bit stop
        if (cnt0_q == CNT_HALF) begin
          state_d = IDLE;
          cnt0_d  = 16'd0;
          cnt1_d  = 3'd0;
          if (synced) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt0_d  = 16'd0;
        cnt1_d  = 3'd0;
      end
    endcase
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt0_q  <= 16'd0;
      cnt1_q  <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_if.data      = data_q;
  assign rx_if.rx_done   = done_q;
  assign rx_if.frame_err = err_q;
  assign rx_if.busy      = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver. It deserialises an 8N1 asynchronous serial stream (1 start, 8 data LSB-first, 1 stop, no parity) into bytes. It sits beside the team's UART transmitter at the FPGA pin boundary and is clocked by the same system clock. Each received byte is presented as a parallel word with a single-cycle valid strobe. Framing errors are flagged separately.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
UART_BPS, 9600, baud rate in bits/s
PERIOD (localparam), CLK_FREQ/UART_BPS, clk cycles per bit (5208 at defaults); must be >= 4 and <= 65535
HALF (localparam), (PERIOD-1)/2, mid-bit sample point (2603 at defaults)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
rx_in  input  1  serial line from pin, asynchronous to clk, idle high
data  output  8  last correctly framed byte
rx_done  output  1  one-cycle pulse: data updated with a new byte
frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset values: data=8'h00, rx_done=0, frame_err=0, busy=0. Internal state=IDLE, counters=0, synchroniser flops=1, shift register=0.
- Input conditioning: 2-flop synchroniser on rx_in, plus 1 history flop. A start edge is synced==0 && prev==1.
- Bit timer cnt0 (16 bit): counts 0..PERIOD-1 while state != IDLE, then wraps to 0. It is cleared on entry to START. Bit index cnt1 (3 bit) counts data bits 0..7.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: on a start edge, go to START with cnt0=0.
- START: at cnt0==HALF, if synced==1 (glitch) go to IDLE with no pulse; otherwise continue. At cnt0==PERIOD-1, go to DATA with cnt1=0.
- DATA: at cnt0==HALF, write the synced bit into shift[cnt1], so the first data bit is data[0]. At cnt0==PERIOD-1, increment cnt1. After bit 7, go to STOP.
- STOP: at cnt0==HALF, sample the stop bit.
  - If 1: data<=shift and rx_done=1 for exactly one cycle.
  - If 0: frame_err=1 for exactly one cycle and data is held.
  - In both cases return to IDLE at that same edge, which allows back-to-back frames with a minimum 1-bit stop.
- rx_done and frame_err are mutually exclusive and never asserted in the same cycle.
- Latency: the pulse rises 9*PERIOD + HALF + 3 (+/-1) clk cycles after the rx_in falling edge at the pin. This is 2 synchroniser cycles plus 1 edge-detect cycle.
- Break or line stuck low: after frame_err, no new frame starts until the line returns high and falls again, because a start edge is required.
- Falling edges during START/DATA/STOP are ignored; there is no resynchronisation within a frame.
- Reset mid-frame: all outputs and state return to reset values immediately (async). The next start edge after release is received normally.
- data is stable between rx_done pulses. A consumer must capture it within one frame time.

Decomposition:
- Shared package/include uart_pkg holds:
  - the state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the PERIOD/HALF derivation from CLK_FREQ/UART_BPS, shared with the transmitter;
  - frame constants DATA_BITS=8, FRAME_BITS=10.
- One natural sub-module, uart_rx_sync. It contains the 2-flop synchroniser, reset to 1, plus falling-edge detect, and outputs synced and fall.

Test Plan:
1. Send 0xA5 at 9600 baud / 50 MHz, stop=1 -> data=0xA5; exactly one rx_done at nominal latency +/-1; frame_err never asserted; busy falls with the pulse.
2. Send 0x00 then 0xFF back-to-back with a 1-bit stop -> two rx_done pulses, data=0x00 then 0xFF, no frame_err.
3. Low glitch on rx_in of 1000 cycles (< HALF), then high -> busy high for ~HALF cycles then 0; no rx_done or frame_err; data unchanged.
4. Send 0x3C with stop bit forced low, then hold low for 20 bit times, then high, then send 0x55:
   - frame_err pulses once and data keeps its previous value;
   - no events occur during the low hold;
   - rx_done follows with data=0x55.
5. Start 0x81, assert rst_n low during data bit 4 for 10 cycles, then send 0x7E -> all outputs at reset values during reset; no pulse for the aborted frame; rx_done with data=0x7E.
6. Send 0x5A with transmitter bit period = PERIOD*1.02, then PERIOD*0.98 -> data=0x5A both times, no frame_err.
